// File: rtl/sdpram16_reader_pkg.sv
// Shared types and constants for the dual-port RAM stream reader.
package sdpram16_reader_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StFlush
    } state_e;

    localparam int unsigned RD_LATENCY = 2;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned DATA_WIDTH = 16;

endpackage

// File: rtl/sdpram16_reader_fifo.sv
// First-word-fall-through output FIFO; push and pop may coincide when full.
module sdpram16_reader_fifo
    import sdpram16_reader_pkg::*;
#(
    parameter int unsigned Width = DATA_WIDTH,
    parameter int unsigned Depth = FIFO_DEPTH,
    localparam int unsigned PtrW = $clog2(Depth)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             valid_o,
    output logic [PtrW:0]    count_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]    count_q;
    logic             do_push, do_pop;

    assign valid_o = (count_q != '0);
    assign do_pop  = pop_i && valid_o;
    assign do_push = push_i && ((count_q != (PtrW + 1)'(Depth)) || do_pop);
    // Drive zero when empty so the data port reads 0 after reset and clear.
    assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PtrW + 1)'(1);
                2'b01:   count_q <= count_q - (PtrW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/sdpram16_reader.sv
// Streams a block of words out of a dual-port RAM read port into a valid/ready stream.
// Optional SDPRAM16_READER_LAST_EN adds out_last flagging the final word of a transfer.
module sdpram16_reader
    import sdpram16_reader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [LEN_WIDTH-1:0]  start_len,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_read_addr,
    output logic                  ram_read_enable,
    input  logic                  ram_write_busy,
    input  logic [15:0]           ram_read_data,
`ifdef SDPRAM16_READER_LAST_EN
    output logic                  out_last,
`endif
    output logic [15:0]           out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
`ifdef SDPRAM16_READER_LAST_EN
    localparam int unsigned FifoW = DATA_WIDTH + 1;
`else
    localparam int unsigned FifoW = DATA_WIDTH;
`endif

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic [LEN_WIDTH-1:0]   issued_q, issued_d;
    logic [RD_LATENCY-1:0]  infl_q;
    logic                   zero_done_q, zero_done_d;
    logic                   xfer_done, in_xfer, credit_ok;
    logic                   fifo_clear, fifo_push;
    logic [CntW-1:0]        fifo_count;
    logic [3:0]             occ;
    logic [FifoW-1:0]       fifo_wdata, fifo_rdata;

    // Occupancy counts words already promised to the FIFO by reads in flight.
    assign occ       = 4'(fifo_count) + 4'($countones(infl_q));
    assign credit_ok = occ < 4'(FIFO_DEPTH);
    assign in_xfer   = (state_q == StRun) || (state_q == StDrain);

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        len_d           = len_q;
        issued_d        = issued_q;
        zero_done_d     = 1'b0;
        xfer_done       = 1'b0;
        ram_read_enable = (state_q == StRun) && !abort && !ram_write_busy
                          && (issued_q < len_q) && credit_ok;
        fifo_clear      = in_xfer && abort;
        fifo_push       = infl_q[RD_LATENCY-1] && in_xfer && !abort;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    addr_d   = start_addr;
                    len_d    = start_len;
                    issued_d = '0;
                    if (start_len == '0) zero_done_d = 1'b1;
                    else                 state_d     = StRun;
                end
            end
            StRun: begin
                if (abort) begin
                    state_d = StFlush;
                end else begin
                    if (ram_read_enable) begin
                        addr_d   = addr_q + ADDR_WIDTH'(1);
                        issued_d = issued_q + LEN_WIDTH'(1);
                    end
                    if (issued_d == len_q) state_d = StDrain;
                end
            end
            StDrain: begin
                if (abort) begin
                    state_d = StFlush;
                end else if ((infl_q == '0) && (fifo_count == '0)) begin
                    state_d   = StIdle;
                    xfer_done = 1'b1;
                end
            end
            StFlush: begin
                if (infl_q == '0) begin
                    state_d   = StIdle;
                    xfer_done = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            len_q       <= '0;
            issued_q    <= '0;
            infl_q      <= '0;
            zero_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            issued_q    <= issued_d;
            infl_q      <= {infl_q[RD_LATENCY-2:0], ram_read_enable};
            zero_done_q <= zero_done_d;
        end
    end

    assign busy          = (state_q != StIdle);
    assign done          = zero_done_q | xfer_done;
    assign ram_read_addr = addr_q;

`ifdef SDPRAM16_READER_LAST_EN
    logic [RD_LATENCY-1:0] last_q;
    logic                  is_last;

    assign is_last = (issued_q == len_q - LEN_WIDTH'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) last_q <= '0;
        else       last_q <= {last_q[RD_LATENCY-2:0], ram_read_enable && is_last};
    end

    assign fifo_wdata = {last_q[RD_LATENCY-1], ram_read_data};
    assign out_last   = fifo_rdata[DATA_WIDTH];
`else
    assign fifo_wdata = ram_read_data;
`endif
    assign out_data = fifo_rdata[DATA_WIDTH-1:0];

    sdpram16_reader_fifo #(
        .Width (FifoW),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .clear_i (fifo_clear),
        .push_i  (fifo_push),
        .data_i  (fifo_wdata),
        .pop_i   (out_ready),
        .data_o  (fifo_rdata),
        .valid_o (out_valid),
        .count_o (fifo_count)
    );

endmodule

// File: tb/tb_sdpram16_reader.sv
// Directed self-checking bench for sdpram16_reader with a 2-cycle-latency RAM model.
module tb_sdpram16_reader;

    localparam int unsigned AW = 10;
    localparam int unsigned LW = 11;

    logic          clk = 1'b0;
    logic          reset, start, abort;
    logic [AW-1:0] start_addr;
    logic [LW-1:0] start_len;
    logic          busy, done, ram_read_enable, ram_write_busy;
    logic [AW-1:0] ram_read_addr;
    logic [15:0]   ram_read_data, out_data;
    logic          out_valid, out_ready;
`ifdef SDPRAM16_READER_LAST_EN
    logic          out_last;
`endif

    sdpram16_reader #(
        .ADDR_WIDTH (AW),
        .LEN_WIDTH  (LW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .start_addr      (start_addr),
        .start_len       (start_len),
        .abort           (abort),
        .busy            (busy),
        .done            (done),
        .ram_read_addr   (ram_read_addr),
        .ram_read_enable (ram_read_enable),
        .ram_write_busy  (ram_write_busy),
        .ram_read_data   (ram_read_data),
`ifdef SDPRAM16_READER_LAST_EN
        .out_last        (out_last),
`endif
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int rdy_mode = 0;
    int wb_lo = -10;
    int wb_hi = -10;
    assign out_ready      = (rdy_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
    assign ram_write_busy = (cyc >= wb_lo) && (cyc <= wb_hi);

    function automatic logic [15:0] ram_word(input logic [AW-1:0] a);
        return (16'(a) * 16'd41) ^ 16'h5A3C;
    endfunction

    // RAM model: word valid two edges after the accepted read, garbage when dropped.
    logic [15:0] d1_q = 16'h0, d2_q = 16'h0;
    always @(posedge clk) begin
        d1_q <= (ram_read_enable && !ram_write_busy) ? ram_word(ram_read_addr) : 16'hDEAD;
        d2_q <= d1_q;
    end
    assign ram_read_data = d2_q;

    logic [AW-1:0] rd_q[$];
    int            rd_cyc[$];
    logic [15:0]   out_q[$];
    int            xf_cyc[$];
    int            val_cyc[$];
    bit            lastf_q[$];
    int            done_cnt = 0, done_cyc = -1, collide = 0;
    int            occ = 0, occ_max = 0;
    bit            occ_en = 1'b0;

    always @(negedge clk) begin
        if (!occ_en) begin
            occ     = 0;
            occ_max = 0;
        end else begin
            if (occ > occ_max) occ_max = occ;
            occ = occ + int'(ram_read_enable) - int'(out_valid && out_ready);
        end
        if (ram_read_enable) begin
            rd_q.push_back(ram_read_addr);
            rd_cyc.push_back(cyc);
            if (ram_write_busy) collide++;
        end
        if (out_valid) val_cyc.push_back(cyc);
        if (out_valid && out_ready) begin
            out_q.push_back(out_data);
            xf_cyc.push_back(cyc);
`ifdef SDPRAM16_READER_LAST_EN
            lastf_q.push_back(out_last);
`endif
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    int nchk = 0, npass = 0;
    int start_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic do_start(input logic [AW-1:0] a, input logic [LW-1:0] n);
        start      = 1'b1;
        start_addr = a;
        start_len  = n;
        @(posedge clk);
        #1;
        start     = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_done(input string tag, input int base, input int budget);
        int n = 0;
        while (done_cnt == base && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_done_seen"}, 32'(done_cnt > base), 32'd1);
    endtask

    task automatic check_words(input string tag, input int ob, input logic [AW-1:0] a,
                               input int n);
        chk({tag, "_nwords"}, 32'(out_q.size() - ob), 32'(n));
        for (int i = 0; i < n && (ob + i) < out_q.size(); i++)
            chk({tag, "_data"}, 32'(out_q[ob + i]), 32'(ram_word(a + AW'(i))));
    endtask

    initial begin
        int ob, rb, vb, db, sc, cnt;
        reset      = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        start_addr = '0;
        start_len  = '0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_rden", 32'(ram_read_enable), 32'd0);
        chk("rst_rdaddr", 32'(ram_read_addr), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Basic transfer: timing and throughput with out_ready high
        ob = out_q.size(); rb = rd_q.size(); vb = val_cyc.size(); db = done_cnt;
        do_start(10'h010, 11'd8);
        sc = start_cyc;
        wait_done("t1", db, 60);
        repeat (3) @(posedge clk);
        #1;
        check_words("t1", ob, 10'h010, 8);
        chk("t1_nreads", 32'(rd_q.size() - rb), 32'd8);
        chk("t1_first_valid", 32'(val_cyc[vb] - sc), 32'd3);
        chk("t1_last_xfer", 32'(xf_cyc[ob + 7] - sc), 32'd10);
        chk("t1_done_lat", 32'(done_cyc - xf_cyc[ob + 7]), 32'd1);
        chk("t1_ndone", 32'(done_cnt - db), 32'd1);
        chk("t1_idle", 32'(busy), 32'd0);
`ifdef SDPRAM16_READER_LAST_EN
        cnt = 0;
        for (int i = ob; i < lastf_q.size(); i++) cnt += int'(lastf_q[i]);
        chk("t1_nlast", 32'(cnt), 32'd1);
        chk("t1_last_pos", 32'(lastf_q[ob + 7]), 32'd1);
`endif

        // Zero-length request
        rb = rd_q.size(); db = done_cnt;
        do_start(10'h055, 11'd0);
        @(negedge clk);
        chk("t0_done", 32'(done), 32'd1);
        chk("t0_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("t0_done_pulse", 32'(done), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("t0_nreads", 32'(rd_q.size() - rb), 32'd0);
        chk("t0_ndone", 32'(done_cnt - db), 32'd1);

        // Address wrap, with a second start that must be ignored
        ob = out_q.size(); rb = rd_q.size(); db = done_cnt;
        do_start(10'h3FE, 11'd4);
        @(posedge clk);
        #1;
        start = 1'b1; start_addr = 10'h200; start_len = 11'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("t2", db, 60);
        repeat (3) @(posedge clk);
        #1;
        chk("t2_nreads", 32'(rd_q.size() - rb), 32'd4);
        chk("t2_addr0", 32'(rd_q[rb]), 32'h3FE);
        chk("t2_addr1", 32'(rd_q[rb + 1]), 32'h3FF);
        chk("t2_addr2", 32'(rd_q[rb + 2]), 32'h000);
        chk("t2_addr3", 32'(rd_q[rb + 3]), 32'h001);
        check_words("t2", ob, 10'h3FE, 4);
        chk("t2_ndone", 32'(done_cnt - db), 32'd1);

        // Back-pressure: out_ready high one cycle in three
        ob = out_q.size(); db = done_cnt;
        occ_en = 1'b1; rdy_mode = 1;
        do_start(10'h3F8, 11'd16);
        wait_done("t3", db, 300);
        chk("t3_occ_bound", 32'(occ_max <= 4), 32'd1);
        chk("t3_occ_filled", 32'(occ_max >= 3), 32'd1);
        occ_en = 1'b0; rdy_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        check_words("t3", ob, 10'h3F8, 16);

        // RAM write collisions in cycles 2..4 after start
        ob = out_q.size(); rb = rd_q.size(); db = done_cnt;
        cnt = collide;
        do_start(10'h140, 11'd8);
        sc = start_cyc;
        wb_lo = sc + 2; wb_hi = sc + 4;
        wait_done("t4", db, 60);
        wb_lo = -10; wb_hi = -10;
        repeat (3) @(posedge clk);
        #1;
        chk("t4_collide", 32'(collide - cnt), 32'd0);
        chk("t4_nreads", 32'(rd_q.size() - rb), 32'd8);
        chk("t4_resume", 32'(rd_cyc[rb + 2] - sc), 32'd5);
        chk("t4_last_rd", 32'(rd_cyc[rb + 7] - sc), 32'd10);
        check_words("t4", ob, 10'h140, 8);

        // Abort three cycles after start
        ob = out_q.size(); rb = rd_q.size(); vb = val_cyc.size(); db = done_cnt;
        do_start(10'h020, 11'd100);
        sc = start_cyc;
        repeat (3) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        wait_done("t5", db, 30);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_done_lat", 32'(done_cyc - sc), 32'd5);
        repeat (4) @(posedge clk);
        #1;
        check_words("t5", ob, 10'h020, 1);
        chk("t5_nreads", 32'(rd_q.size() - rb), 32'd3);
        cnt = 0;
        for (int i = vb; i < val_cyc.size(); i++) if (val_cyc[i] > sc + 3) cnt++;
        chk("t5_no_stale", 32'(cnt), 32'd0);
        chk("t5_ndone", 32'(done_cnt - db), 32'd1);

        // Abort in IDLE ignored; start wins over abort in the same cycle
        db = done_cnt;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("t6_idle_abort", 32'(busy), 32'd0);
        ob = out_q.size();
        abort = 1'b1;
        do_start(10'h100, 11'd2);
        abort = 1'b0;
        chk("t6_started", 32'(busy), 32'd1);
        wait_done("t6", db, 40);
        repeat (3) @(posedge clk);
        #1;
        check_words("t6", ob, 10'h100, 2);

        // Reset mid-transfer abandons without done
        db = done_cnt;
        do_start(10'h000, 11'd20);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("t7_busy", 32'(busy), 32'd0);
        chk("t7_valid", 32'(out_valid), 32'd0);
        chk("t7_rden", 32'(ram_read_enable), 32'd0);
        chk("t7_rdaddr", 32'(ram_read_addr), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("t7_no_done", 32'(done_cnt - db), 32'd0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sdpram16_reader.md
SDPRAM16_READER -- requirements
Module: sdpram16_reader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, RAM word-address width.
REQ-002 SHALL have parameter LEN_WIDTH, default ADDR_WIDTH+1, transfer-length width in words.
REQ-003 SHALL have port clk  input  1  sole clock, all logic rising-edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a transfer.
REQ-006 SHALL have port start_addr  input  ADDR_WIDTH  first word address.
REQ-007 SHALL have port start_len  input  LEN_WIDTH  number of words to stream.
REQ-008 SHALL have port abort  input  1  cancel the current transfer.
REQ-009 SHALL have port busy  output  1  high while not IDLE.
REQ-010 SHALL have port done  output  1  one-cycle pulse at transfer completion or abort completion.
REQ-011 SHALL have port ram_read_addr  output  ADDR_WIDTH  address to the dual-port RAM read port.
REQ-012 SHALL have port ram_read_enable  output  1  read strobe to the RAM.
REQ-013 SHALL have port ram_write_busy  input  1  the RAM write_enable; when high, the RAM drops reads.
REQ-014 SHALL have port ram_read_data  input  16  RAM read data, valid 2 cycles after an accepted read.
REQ-015 SHALL have ports out_data (output, 16), out_valid (output, 1), out_ready (input, 1): stream, transfer when out_valid && out_ready.

Function
REQ-016 SHALL implement states IDLE, RUN, DRAIN, FLUSH.
REQ-017 IDLE: start latches start_addr/start_len; len 0 -> done pulse next cycle, no reads, stay IDLE; else -> RUN.
REQ-018 start SHALL be ignored outside IDLE.
REQ-019 RUN: ram_read_enable SHALL be asserted only when words_issued < len, ram_write_busy low, and (FIFO occupancy + in-flight reads) < 4.
REQ-020 A read SHALL never be issued while ram_write_busy is high; address and issue count do not advance that cycle.
REQ-021 ram_read_addr SHALL increment after each issued read and wrap modulo 2**ADDR_WIDTH.
REQ-022 In-flight tracking SHALL be a 2-stage valid shift register; data captured into the FIFO exactly 2 cycles after issue.
REQ-023 RUN -> DRAIN once words_issued == len; DRAIN -> IDLE with done pulse once in-flight and FIFO are empty.
REQ-024 Output FIFO SHALL be 4 words deep, first-word-fall-through; out_valid = FIFO not empty; simultaneous push and pop allowed at full.
REQ-025 Credit rule of REQ-019 SHALL guarantee the FIFO never overflows under any out_ready pattern.
REQ-026 abort in RUN or DRAIN SHALL stop issue immediately, clear the FIFO, deassert out_valid next cycle, enter FLUSH.
REQ-027 FLUSH SHALL discard returning in-flight data, then go IDLE with done pulse; abort in IDLE/FLUSH ignored.
REQ-028 abort and start in the same IDLE cycle: start wins.
REQ-029 Throughput SHALL be one word per cycle with out_ready held high and no write collisions.

Reset
REQ-030 reset SHALL force IDLE, busy=0, done=0, out_valid=0, out_data=0, ram_read_enable=0, ram_read_addr=0, in-flight and FIFO cleared.
REQ-031 reset mid-transfer SHALL abandon it without a done pulse.

Configuration
REQ-032 Macro SDPRAM16_READER_LAST_EN SHALL, when defined, add output out_last (1 bit), high with the final word of a transfer; reset value 0.
REQ-033 Without SDPRAM16_READER_LAST_EN, port out_last and its logic SHALL not exist; all other behaviour identical.

Structure
REQ-034 Package sdpram16_reader_pkg SHALL hold the state enum, RD_LATENCY=2 and FIFO_DEPTH=4.
REQ-035 FIFO SHALL be sub-module sdpram16_reader_fifo (16-bit, depth FIFO_DEPTH, plus last bit when enabled).

Verification
REQ-036 start addr 0x010 len 8, out_ready=1 -> words from 0x010..0x017 in order, first out_valid 3 cycles after start, done 1 cycle after last transfer.
REQ-037 start addr 0x3FE len 4, ADDR_WIDTH=10 -> reads 0x3FE,0x3FF,0x000,0x001.
REQ-038 len 16, out_ready toggling 1-of-3 cycles -> all 16 words, no loss/duplication, occupancy+in-flight never >4.
REQ-039 len 8, ram_write_busy high cycles 2-4 after start -> no ram_read_enable those cycles, 8 correct words.
REQ-040 abort 3 cycles after start len 100 -> out_valid low next cycle, no stale word emitted, done after 2 further cycles, busy low.
REQ-041 start len 0 -> done pulse next cycle, no ram_read_enable; with SDPRAM16_READER_LAST_EN, out_last only on final word of REQ-036.
